rr_sel_scheduler: RTL

//  Round-robin scheduler that drives the 2-bit select of the downstream 4:1 nibble selector.

---
 rtl/rr_sel_scheduler_pkg.sv | 23 ++
 rtl/rr_sel_scheduler_pick4.sv | 28 ++
 rtl/rr_sel_scheduler.sv | 119 +++++++++++
 3 files changed

// File: rtl/rr_sel_scheduler_pkg.sv
// Shared constants, state encoding and helpers for the round-robin select scheduler.
// Sized around the downstream 4:1 nibble selector.
package rr_sel_scheduler_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  // Legacy-compatible state encoding
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  function automatic logic [NCH-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [NCH-1:0] v;
    v = {{(NCH-1){1'b0}}, 1'b1} << s;
    return v;
  endfunction

endpackage

// File: rtl/rr_sel_scheduler_pick4.sv
// Rotating-priority picker: first set request at or after ptr, wrapping 3->0.
module rr_pick4
  import rr_sel_scheduler_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  // Scan from the farthest offset down so the nearest hit to ptr is kept last
  always_comb begin
    idx = ptr;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req[ptr + SEL_W'(k)]) begin
        idx = ptr + SEL_W'(k);
      end else begin
        idx = idx;
      end
    end
  end

  // Any request at all means the scan above landed on a real requester
  always_comb begin
    found = |req;
  end

endmodule

// File: rtl/rr_sel_scheduler.sv
// Round-robin scheduler driving the 2-bit select of the 4:1 nibble selector,
// with a per-grant beat quantum, valid/ready toward the consumer and per-source ack.
module rr_sel_scheduler
  import rr_sel_scheduler_pkg::*;
#(
  parameter int QUANTUM = 4,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic [NCH-1:0]   grant,
  output logic             out_valid,
  output logic [NCH-1:0]   ack,
  output logic             busy
);

  logic [0:0]       state_r;
  logic [SEL_W-1:0] sel_r;
  logic [NCH-1:0]   grant_r;
  logic [SEL_W-1:0] ptr_r;
  logic [CNT_W-1:0] beat_cnt_r;

  logic [NCH-1:0]   pick_req_s;
  logic [SEL_W-1:0] pick_ptr_s;
  pick_t            pick_s;
  logic             in_grant_s;
  logic             valid_s;
  logic             xfer_s;
  logic             last_beat_s;
  logic             release_s;

  // Handshake qualification and release decision for the current grant
  always_comb begin
    in_grant_s  = (state_r == S_GRANT);
    valid_s     = in_grant_s & req[sel_r];
    xfer_s      = valid_s & out_ready;
    last_beat_s = (beat_cnt_r == CNT_W'(QUANTUM - 1));
    release_s   = in_grant_s & (~req[sel_r] | (xfer_s & last_beat_s));
  end

  // On release the re-pick starts after the current owner and excludes it
  always_comb begin
    if (in_grant_s) begin
      pick_req_s = req & ~grant_r;
      pick_ptr_s = sel_r + SEL_W'(1);
    end else begin
      pick_req_s = req;
      pick_ptr_s = ptr_r;
    end
  end

  rr_pick4 u_pick (
    .req   (pick_req_s),
    .ptr   (pick_ptr_s),
    .idx   (pick_s.idx),
    .found (pick_s.found)
  );

  // State, select, grant, pointer and beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      sel_r      <= {SEL_W{1'b0}};
      grant_r    <= {NCH{1'b0}};
      ptr_r      <= {SEL_W{1'b0}};
      beat_cnt_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (pick_s.found) begin
            state_r    <= S_GRANT;
            sel_r      <= pick_s.idx;
            grant_r    <= onehot(pick_s.idx);
            beat_cnt_r <= {CNT_W{1'b0}};
          end
        end
        S_GRANT: begin
          if (release_s) begin
            ptr_r <= sel_r + SEL_W'(1);
            // Back-to-back handover when another source is waiting
            if (pick_s.found) begin
              sel_r      <= pick_s.idx;
              grant_r    <= onehot(pick_s.idx);
              beat_cnt_r <= {CNT_W{1'b0}};
            end else begin
              state_r    <= S_IDLE;
              grant_r    <= {NCH{1'b0}};
              beat_cnt_r <= {CNT_W{1'b0}};
            end
          end else if (xfer_s) begin
            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r    <= S_IDLE;
          grant_r    <= {NCH{1'b0}};
          beat_cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // grant_r is the one-hot of sel during a grant, so it doubles as the ack mask
  always_comb begin
    sel       = sel_r;
    grant     = grant_r;
    busy      = in_grant_s;
    out_valid = valid_s;
    if (xfer_s) begin
      ack = grant_r;
    end else begin
      ack = {NCH{1'b0}};
    end
  end

endmodule
